// File: rtl/puart_pkg.sv
// puart_pkg: definitions shared by the puart block.
//   - parity mode constants for the PARITY parameter
//   - receive state machine encoding
//   - oversample factor (ticks per bit)
//   - parity helper used by both the transmitter and the receiver
package puart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    // Parity bit for an already-masked character. Odd mode makes data plus
    // parity carry odd weight, even mode even weight.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/puart_tick.sv
// puart_tick: free-running oversample tick divider.
// Ports:
//   clk    - clock, rising edge
//   resetq - asynchronous active-low reset (counter cleared)
//   tick   - one-cycle pulse every DIV cycles; every cycle when DIV <= 1
module puart_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic resetq,
    output logic tick
);

    // A clock slower than 16x the line rate still gets a tick every cycle.
    localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
    localparam int CW      = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV_EFF - 1));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/puart.sv
// puart: parameterised UART with a receive FIFO.
// Ports:
//   clk, resetq       - clock (rising edge) and asynchronous active-low reset
//   rx / tx           - serial receive (asynchronous) and transmit lines
//   wr, tx_data, busy - transmit strobe, character, frame-in-progress flag
//   rd, valid         - FIFO pop strobe and FIFO-not-empty flag
//   rx_data,perr,ferr - FIFO head character and its error flags (0 when empty)
//   overrun           - sticky: a received character was dropped on a full FIFO
module puart
    import puart_pkg::*;
#(
    parameter int CLKFREQ  = 50000000,
    parameter int BAUD     = 115200,
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1,
    parameter int RXDEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       rx,
    output logic       tx,
    input  logic       wr,
    input  logic [7:0] tx_data,
    output logic       busy,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] rx_data,
    output logic       perr,
    output logic       ferr,
    output logic       overrun
);

    localparam int         DIV     = CLKFREQ / (OVERSAMPLE * BAUD);
    localparam int         HASPAR  = (PARITY != PAR_NONE) ? 1 : 0;
    localparam int         NBITS   = 1 + DATABITS + HASPAR + STOPBITS;
    localparam logic [7:0] DMASK   = 8'((1 << DATABITS) - 1);
    localparam int         AW      = $clog2(RXDEPTH);
    localparam logic [3:0] PH_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] PH_MID  = 4'(OVERSAMPLE / 2 - 1);

    logic tick;

    puart_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .resetq (resetq),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // Transmitter: whole frame built at accept time, shifted out LSB first.
    // ------------------------------------------------------------------
    logic [7:0]       tx_masked;
    logic [NBITS-1:0] tx_frame;
    logic [NBITS-1:0] tx_shift;
    logic [3:0]       tx_phase;
    logic [3:0]       tx_left;

    assign tx_masked = tx_data & DMASK;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tx_frame    = '1;
        tx_frame[0] = 1'b0;
        for (int i = 0; i < DATABITS; i++) begin
            tx_frame[1 + i] = tx_masked[i];
        end
        if (HASPAR != 0) begin
            tx_frame[1 + DATABITS] = parity_bit(tx_masked, PARITY);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_shift <= '1;
            tx_phase <= '0;
            tx_left  <= '0;
        end else if (!busy) begin
            if (wr) begin
                busy     <= 1'b1;
                tx       <= tx_frame[0];
                tx_shift <= tx_frame >> 1;
                tx_left  <= 4'(NBITS - 1);
                tx_phase <= '0;
            end
        end else if (tick) begin
            tx_phase <= tx_phase + 4'd1;
            if (tx_phase == PH_LAST) begin
                if (tx_left == 4'd0) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    tx       <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_left  <= tx_left - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver: two-flop synchroniser, edge detect, centre sampling.
    // ------------------------------------------------------------------
    logic [1:0]          rx_sync;
    logic                rx_s;
    logic                rx_prev;
    rx_state_t           rx_state, rx_state_d;
    logic [3:0]          rx_phase, rx_phase_d;
    logic [DATABITS-1:0] rx_shift, rx_shift_d;
    logic [2:0]          rx_cnt, rx_cnt_d;
    logic                rx_perr, rx_perr_d;
    logic                push;
    logic [9:0]          push_entry;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_phase <= '0;
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rx_s;
            rx_state <= rx_state_d;
            rx_phase <= rx_phase_d;
            rx_shift <= rx_shift_d;
            rx_cnt   <= rx_cnt_d;
            rx_perr  <= rx_perr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_phase_d = rx_phase;
        rx_shift_d = rx_shift;
        rx_cnt_d   = rx_cnt;
        rx_perr_d  = rx_perr;
        push       = 1'b0;
        // Entry is only consumed in STOP, where rx_s is the first stop bit.
        push_entry = {rx_perr, ~rx_s, 8'(rx_shift)};
        unique case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_d = START;
                    rx_phase_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    rx_phase_d = rx_phase + 4'd1;
                    if (rx_phase == PH_MID) begin
                        rx_phase_d = '0;
                        if (rx_s) begin
                            rx_state_d = IDLE;
                        end else begin
                            rx_state_d = DATA;
                            rx_cnt_d   = '0;
                            rx_perr_d  = 1'b0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    rx_phase_d = rx_phase + 4'd1;
                    if (rx_phase == PH_LAST) begin
                        rx_shift_d = {rx_s, rx_shift[DATABITS-1:1]};
                        rx_cnt_d   = rx_cnt + 3'd1;
                        if (rx_cnt == 3'(DATABITS - 1)) begin
                            rx_state_d = (HASPAR != 0) ? PAR : STOP;
                        end
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    rx_phase_d = rx_phase + 4'd1;
                    if (rx_phase == PH_LAST) begin
                        rx_perr_d  = (rx_s != parity_bit(8'(rx_shift), PARITY));
                        rx_state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    rx_phase_d = rx_phase + 4'd1;
                    if (rx_phase == PH_LAST) begin
                        push       = 1'b1;
                        rx_state_d = IDLE;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO: entries are {perr, ferr, data[7:0]}.
    // ------------------------------------------------------------------
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(RXDEPTH);

    logic [9:0]    mem [RXDEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, pop, accept;
    logic [9:0]    head;

    assign full   = (count == DEPTH_C);
    assign valid  = (count != '0);
    assign pop    = rd && valid;
    // A pop in the same cycle frees the slot the push needs.
    assign accept = push && (!full || pop);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overrun <= 1'b1;
            end else if (pop) begin
                overrun <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; outputs are gated by valid, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= push_entry;
        end
    end

    assign head    = mem[rptr];
    assign rx_data = valid ? head[7:0] : 8'h00;
    assign ferr    = valid && head[8];
    assign perr    = valid && head[9];

endmodule

// File: tb/tb_puart.sv
// tb_puart: self-checking bench for puart. Two instances share clk/resetq:
// u_a is 8N1 (defaults), u_b is 7 data bits with even parity. DIV=1, so a
// bit lasts 16 cycles. Expected frames and FIFO contents come from a
// frame-level model (bit lists and a bounded queue).
module tb_puart;

    logic clk = 1'b0;
    logic resetq;

    logic       rx_a, tx_a, wr_a, busy_a, rd_a, valid_a, perr_a, ferr_a, ovr_a;
    logic [7:0] txd_a, rxd_a;
    logic       rx_b, tx_b, wr_b, busy_b, rd_b, valid_b, perr_b, ferr_b, ovr_b;
    logic [7:0] txd_b, rxd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    puart #(.CLKFREQ(1843200), .BAUD(115200)) u_a (
        .clk(clk), .resetq(resetq), .rx(rx_a), .tx(tx_a), .wr(wr_a),
        .tx_data(txd_a), .busy(busy_a), .rd(rd_a), .valid(valid_a),
        .rx_data(rxd_a), .perr(perr_a), .ferr(ferr_a), .overrun(ovr_a)
    );

    puart #(.CLKFREQ(1843200), .BAUD(115200), .DATABITS(7), .PARITY(2)) u_b (
        .clk(clk), .resetq(resetq), .rx(rx_b), .tx(tx_b), .wr(wr_b),
        .tx_data(txd_b), .busy(busy_b), .rd(rd_b), .valid(valid_b),
        .rx_data(rxd_b), .perr(perr_b), .ferr(ferr_b), .overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line-level frame: start, data LSB first, optional parity, stop bits.
    function automatic int make_frame(input logic [7:0] d, input int db, input int par,
                                      input int sb, input logic flip_par, input logic bad_stop,
                                      output logic [11:0] bits);
        int n;
        int ones;
        logic [7:0] m;
        logic p;
        m = 8'hFF >> (8 - db);
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin
            bits[n] = d[i]; n++;
        end
        if (par != 0) begin
            ones = $countones(d & m);
            p = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            bits[n] = p ^ flip_par; n++;
        end
        for (int s = 0; s < sb; s++) begin
            bits[n] = (s == 0 && bad_stop) ? 1'b0 : 1'b1; n++;
        end
        return n;
    endfunction

    // Called at a negedge with the transmitter idle; returns at the negedge
    // just after busy should have fallen, so a following call tests
    // back-to-back accept.
    task automatic tx_frame_check(input int sel, input logic [7:0] d, input string tag);
        logic [11:0] bits;
        int n;
        n = (sel != 0) ? make_frame(d, 7, 2, 1, 1'b0, 1'b0, bits)
                       : make_frame(d, 8, 0, 1, 1'b0, 1'b0, bits);
        if (sel != 0) begin wr_b = 1'b1; txd_b = d; end
        else          begin wr_a = 1'b1; txd_a = d; end
        @(negedge clk);
        wr_a = 1'b0; wr_b = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            check({tag, "_bit"}, 32'((sel != 0) ? tx_b : tx_a), 32'(bits[k]));
            check({tag, "_busy"}, 32'((sel != 0) ? busy_b : busy_a), 32'd1);
            if (k < n - 1) repeat (16) @(negedge clk);
        end
        repeat (7) @(negedge clk);
        check({tag, "_busy_last"}, 32'((sel != 0) ? busy_b : busy_a), 32'd1);
        @(negedge clk);
        check({tag, "_busy_end"}, 32'((sel != 0) ? busy_b : busy_a), 32'd0);
        check({tag, "_tx_idle"}, 32'((sel != 0) ? tx_b : tx_a), 32'd1);
    endtask

    task automatic drive_line(input int sel, input logic [11:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            if (sel != 0) rx_b = bits[k]; else rx_a = bits[k];
            repeat (16) @(negedge clk);
        end
        if (sel != 0) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    // Compare FIFO head against {perr, ferr, data}, then pop it.
    task automatic rx_check(input int sel, input logic [9:0] e, input string tag);
        check({tag, "_valid"}, 32'((sel != 0) ? valid_b : valid_a), 32'd1);
        check({tag, "_data"},  32'((sel != 0) ? rxd_b : rxd_a), 32'(e[7:0]));
        check({tag, "_ferr"},  32'((sel != 0) ? ferr_b : ferr_a), 32'(e[8]));
        check({tag, "_perr"},  32'((sel != 0) ? perr_b : perr_a), 32'(e[9]));
        if (sel != 0) rd_b = 1'b1; else rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0; rd_b = 1'b0;
        check({tag, "_empty"}, 32'((sel != 0) ? valid_b : valid_a), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] bits;
        int          n;
        logic [7:0]  d;
        logic        fp, bs, ovr_m;
        logic [9:0]  q[$];

        resetq = 1'b0;
        rx_a = 1'b1; wr_a = 1'b0; txd_a = 8'h00; rd_a = 1'b0;
        rx_b = 1'b1; wr_b = 1'b0; txd_b = 8'h00; rd_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, during and after reset.
        check("rst_tx",    32'(tx_a),    32'd1);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data",  32'(rxd_a),   32'd0);
        check("rst_perr",  32'(perr_a),  32'd0);
        check("rst_ferr",  32'(ferr_a),  32'd0);
        check("rst_ovr",   32'(ovr_a),   32'd0);
        check("rst_tx_b",  32'(tx_b),    32'd1);
        resetq = 1'b1;
        @(negedge clk);
        check("post_rst_tx",    32'(tx_a),    32'd1);
        check("post_rst_valid", 32'(valid_b), 32'd0);

        // TX: A5 on 8N1, then back-to-back random characters.
        tx_frame_check(0, 8'hA5, "tx_a5");
        for (int i = 0; i < 3; i++) tx_frame_check(0, 8'($urandom), "tx_rand_a");
        for (int i = 0; i < 3; i++) tx_frame_check(1, 8'($urandom), "tx_rand_b");

        // RX 7E1: 0x41 with correct parity, then with the parity bit flipped.
        n = make_frame(8'h41, 7, 2, 1, 1'b0, 1'b0, bits);
        check("par_bit_41", 32'(bits[8]), 32'd0);
        drive_line(1, bits, n);
        repeat (3) @(negedge clk);
        rx_check(1, {1'b0, 1'b0, 8'h41}, "rx_41");
        n = make_frame(8'h41, 7, 2, 1, 1'b1, 1'b0, bits);
        drive_line(1, bits, n);
        repeat (3) @(negedge clk);
        rx_check(1, {1'b1, 1'b0, 8'h41}, "rx_41_perr");

        // False start: 5 low cycles only.
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start", 32'(valid_a), 32'd0);

        // Framing error: 0x3C with its stop bit held low.
        n = make_frame(8'h3C, 8, 0, 1, 1'b0, 1'b1, bits);
        drive_line(0, bits, n);
        repeat (3) @(negedge clk);
        rx_check(0, {1'b0, 1'b1, 8'h3C}, "rx_3c_ferr");

        // Overrun: six frames back to back with no reads, model is a
        // depth-4 queue that drops on full.
        ovr_m = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            n = make_frame(8'(v), 8, 0, 1, 1'b0, 1'b0, bits);
            drive_line(0, bits, n);
            if (q.size() < 4) q.push_back({2'b00, 8'(v)});
            else ovr_m = 1'b1;
        end
        repeat (4) @(negedge clk);
        check("ovr_set", 32'(ovr_a), 32'(ovr_m));
        for (int k = 0; q.size() > 0; k++) begin
            check("ovr_valid", 32'(valid_a), 32'd1);
            check("ovr_data",  32'(rxd_a),   32'(q[0][7:0]));
            void'(q.pop_front());
            rd_a = 1'b1;
            @(negedge clk);
            rd_a = 1'b0;
            if (k == 0) check("ovr_clear", 32'(ovr_a), 32'd0);
        end
        check("ovr_drained", 32'(valid_a), 32'd0);

        // Random RX frames with random parity and stop errors.
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            fp = 1'($urandom_range(0, 1));
            bs = ($urandom_range(0, 3) == 0);
            n = make_frame(d, 7, 2, 1, fp, bs, bits);
            drive_line(1, bits, n);
            repeat (3) @(negedge clk);
            rx_check(1, {fp, bs, d & 8'h7F}, "rx_rand_b");
        end
        for (int i = 0; i < 4; i++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(0, 3) == 0);
            n = make_frame(d, 8, 0, 1, 1'b0, bs, bits);
            drive_line(0, bits, n);
            repeat (3) @(negedge clk);
            rx_check(0, {1'b0, bs, d}, "rx_rand_a");
        end

        // Reset mid TX frame and mid RX frame.
        wr_a = 1'b1; txd_a = 8'($urandom);
        @(negedge clk);
        wr_a = 1'b0;
        rx_a = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_busy_pre", 32'(busy_a), 32'd1);
        resetq = 1'b0;
        rx_a = 1'b1;
        #1;
        check("mid_rst_tx",   32'(tx_a),   32'd1);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);
        resetq = 1'b1;
        repeat (200) @(negedge clk);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_idle",  32'(busy_a),  32'd0);
        check("mid_rst_ovr",   32'(ovr_a),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/puart.md
PUART -- requirements
Module: puart

Interface
REQ-001 Parameter CLKFREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATABITS, default 8, data bits per character; legal values are 5 to 8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOPBITS, default 1, stop bits transmitted; legal values are 1 or 2.
REQ-006 Parameter RXDEPTH, default 4, receive FIFO depth in entries; must be a power of 2 and at least 2.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port resetq, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port rx, input, 1 bit: serial receive line, asynchronous to clk.
REQ-010 Port tx, output, 1 bit: serial transmit line.
REQ-011 Port wr, input, 1 bit: transmit strobe.
REQ-012 Port tx_data, input, 8 bits: transmit character; bits above DATABITS-1 are ignored.
REQ-013 Port busy, output, 1 bit: the transmitter is sending a frame.
REQ-014 Port rd, input, 1 bit: pops the receive FIFO head.
REQ-015 Port valid, output, 1 bit: the receive FIFO is not empty.
REQ-016 Port rx_data, output, 8 bits: FIFO head character, zero-padded above DATABITS-1.
REQ-017 Port perr, output, 1 bit: the FIFO head character had a parity error.
REQ-018 Port ferr, output, 1 bit: the FIFO head character had a framing error.
REQ-019 Port overrun, output, 1 bit: sticky flag, set when a received character is lost.

Function
REQ-020 Oversample tick:
- A free-running counter pulses tick for one clk every DIV = CLKFREQ/(16*BAUD) cycles (integer division).
- DIV equal to 1 gives a tick on every cycle.
REQ-021 TX accept: wr while busy=0 latches tx_data; busy rises on the next edge; wr while busy=1 is ignored.
REQ-022 TX frame order:
- start bit (0);
- DATABITS data bits, LSB first;
- parity bit if PARITY is not 0 (odd: the data bits plus parity have odd weight; even: even weight);
- STOPBITS stop bits (1).
REQ-023 TX bit timing:
- each bit lasts 16 ticks;
- tx changes on the edge after wr, then on every 16th tick;
- the start bit may be short by at most one tick period.
REQ-024 TX completion:
- busy falls when the last stop bit has lasted 16 ticks;
- tx stays at 1 while idle;
- back-to-back wr is accepted on the cycle after busy falls.
REQ-025 RX synchroniser: rx passes through two flip-flops before any other use.
REQ-026 RX state machine states: IDLE, START, DATA, PAR, STOP.
REQ-027 IDLE to START: on a synchronised 1-to-0 transition, the tick phase count is cleared.
REQ-028 START check:
- after 8 ticks, if the line is 1, the start is false and the state returns to IDLE with nothing pushed;
- otherwise the state goes to DATA.
REQ-029 DATA: samples every 16 ticks (bit centre) and shifts bits in LSB first; after DATABITS bits it goes to PAR if parity is enabled, else to STOP.
REQ-030 PAR: samples and compares against the computed parity; a mismatch marks perr for this character.
REQ-031 STOP:
- samples the first stop bit only; a 0 marks ferr;
- pushes {perr, ferr, data} into the FIFO and returns to IDLE in the same cycle, so a start edge is detected immediately.
REQ-032 FIFO read:
- rx_data, perr and ferr show the head entry combinationally from the FIFO storage;
- when valid=0 they are 0;
- rd while valid=1 pops on the edge;
- rd while valid=0 is ignored.
REQ-033 FIFO full:
- a push when full with no pop drops the new character and sets overrun;
- a push and a pop in the same cycle when full both succeed, with no overrun.
REQ-034 overrun clears on the edge of any rd while valid=1; if a set occurs in the same cycle as a clear, the set wins.
REQ-035 FIFO pointers wrap modulo RXDEPTH; the occupancy counter is $clog2(RXDEPTH)+1 bits.

Reset
REQ-036 While resetq=0, and on release, the block is in this state:
- tx=1, busy=0, valid=0, rx_data=0, perr=0, ferr=0, overrun=0;
- FIFO empty, RX in IDLE, synchroniser flip-flops at 1, tick counter at 0.
REQ-037 Reset asserted mid-frame aborts both directions immediately; no partial character is pushed.

Structure
REQ-038 Shared package holds:
- the parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
- the RX state encoding;
- the oversample factor constant 16.
REQ-039 The tick divider is one sub-module, puart_tick, with ports clk, resetq and tick; TX, RX and the FIFO are inline.

Verification
REQ-040 The bench uses CLKFREQ=1843200 and BAUD=115200, so DIV=1 and one bit lasts 16 cycles.
REQ-041 Defaults, wr with tx_data=8'hA5 -> tx carries 0,1,0,1,0,0,1,0,1,1 at 16 cycles each; busy is high for 160 cycles, then low.
REQ-042 PARITY=2, DATABITS=7, a line frame carrying 7'h41 with parity bit 0 -> valid=1, rx_data=8'h41, perr=0, ferr=0; the same frame with parity bit 1 -> perr=1.
REQ-043 rx pulsed low for 5 cycles only -> the false start is rejected and valid stays 0.
REQ-044 A frame for 8'h3C with its stop bit held 0 -> rx_data=8'h3C, ferr=1.
REQ-045 RXDEPTH=4, six frames 8'h01 to 8'h06 sent with no rd -> overrun=1; the FIFO reads back 01, 02, 03, 04; overrun clears on the first rd.
REQ-046 resetq pulsed low mid TX frame and mid RX frame -> tx=1 and busy=0 at once; valid=0 after release.
